samp_rej_prep: RTL and testbench
================================

// Module: samp_rej_prep
// PURPOSE
//  Downstream consumer of the SamplerZ pre-sampling stage. Latches r_l/r_r, sqr2_isigma and ccs_63 on pre_done.
//  Per lane pair, takes base-sampler draw z0 and sign bit b. Forms z = b ? z0+1 : -z0.
//  Computes BerExp argument x = (z-r)^2*sqr2_isigma - z0^2*INV_2SIGMA0_SQ on the shared MUL81 pair (l/r lanes in parallel).
//  Hands {x, z, ccs_63} to the BerExp stage over a valid/ready handshake.
// PARAMETERS
//  MUL_LATENCY     0    cycles from MUL_data_valid to MUL_data_out usable (0: sampled same cycle)
//  INV_2SIGMA0_SQ  round(0.150865048875372721532312163019*2^72)  72-bit Q0.72 constant 1/(2*sigma0^2)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  pre_done       in   1   1-cycle pulse: load r_l, r_r, sqr2_isigma, ccs_63
//  r_l, r_r       in   72  fractional part of mu, unsigned Q0.72
//  sqr2_isigma    in   72  isigma^2/2, unsigned Q0.72
//  ccs_63         in   63  ccs for BerExp, passed through
//  in_valid       in   1   z0_l/b_l/z0_r/b_r valid
//  in_ready       out  1   accept when high (IDLE and params loaded)
//  z0_l, z0_r     in   5   base-sampler output, 0..18
//  b_l, b_r       in   1   sign bits
//  MUL_data_valid_l/_r  out  1   strobe to shared multiplier
//  MUL_data_in_a_l/_r   out  81  operand a
//  MUL_data_in_b_l/_r   out  81  operand b
//  MUL_data_out_l/_r    in   81  (a*b)>>72, truncated to 81 bits
//  out_valid      out  1   result valid
//  out_ready      in   1   BerExp accepts
//  x_l, x_r       out  81  unsigned Q9.72, saturated at 0
//  z_l, z_r       out  6   signed two's complement, -18..19
//  ccs_out        out  63  latched ccs_63
//  x_neg          out  2   {r,l}: x was negative and clamped, qualified by out_valid
//  err            out  1   sticky: pre_done seen while not IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, including in_ready and err. params_loaded=0. FSM=IDLE.
//  in_ready = (state==IDLE) & params_loaded.
//  pre_done in IDLE: load param regs, set params_loaded. In any other state: ignore it and set err (cleared only by reset).
//  FSM: IDLE -> SQ -> SC -> SUB -> OUT -> IDLE. WAIT sub-states hold MUL_LATENCY cycles after each issue.
//  IDLE: on in_valid&in_ready, register per lane:
//   z = b ? z0+1 : -z0
//   d = |z*2^72 - r|, 79-bit unsigned
//   zsq = z0*z0, 9 bits
//  SQ: MUL_data_valid=1, a=b={2'b0,d}. Capture d2=MUL_data_out at MUL_LATENCY.
//  SC: MUL_data_valid=1, a=d2, b={9'b0,sqr2_isigma}. Capture t1.
//  SUB: t2=(zsq*INV_2SIGMA0_SQ), local 9x72 multiply, 81 bits.
//   If t1>=t2: x=t1-t2. Else x=0 and x_neg bit=1. Register.
//  OUT: out_valid=1. Hold x/z/ccs_out/x_neg stable until out_ready. Leave to IDLE on out_valid&out_ready.
//  Latency: handshake edge to out_valid = 4+2*MUL_LATENCY cycles. One job in flight.
//  MUL outputs are 0 outside SQ/SC, so the top level may OR them with pre_samp.
//   Top level guarantees no overlap with pre_samp's use.
//  out_ready held low: stall in OUT indefinitely. No new accept.
//  rst_n low mid-job: immediate return to IDLE. out_valid drops asynchronously. params_loaded cleared.
//  Both lanes always processed together. No per-lane valid.
// TESTING
//  Reset then in_valid with no pre_done -> in_ready stays 0. No MUL strobe.
//  Case A. Setup: INV_2SIGMA0_SQ=2^69 (0.125); r_l=0, sqr2_isigma=2^71 (0.5). Stimulus: z0_l=0, b_l=0.
//   -> z_l=0, x_l=0, x_neg[0]=0.
//  Case B. Setup: INV_2SIGMA0_SQ=2^69 (0.125). Stimulus: z0_l=2, b_l=1, r_l=2^71 (0.5), sqr2_isigma=2^71 (0.5).
//   Expect z=3, d=2.5, t1=3.125, t2=0.5.
//   -> z_l=3, x_l=2.625*2^72, out_valid 4 cycles after accept.
//  Case C. Stimulus: z0_r=4, b_r=0, r_r=0, sqr2_isigma=0.
//   -> z_r=-4 (6'h3C), x_r=0, x_neg[1]=1.
//  Case D. Hold out_ready=0 for 10 cycles after out_valid.
//   -> outputs stable, in_ready=0. Accept resumes the cycle after out_ready.
//  Case E. pre_done during SC -> err=1, params unchanged. rst_n pulse mid-SC -> out_valid=0, FSM IDLE, err=0.

Source files
------------

// File: rtl/samp_rej_prep.sv
// samp_rej_prep: forms the signed sample z from the base-sampler draw and the
// sign bit, then computes the BerExp argument
//   x = (z - r)^2 * sqr2_isigma - z0^2 * INV_2SIGMA0_SQ
// for both lanes at once, using the shared 81-bit multipliers for the two
// squarings and a local 9x72 multiply for the constant term.
module samp_rej_prep #(
  parameter int          MUL_LATENCY    = 0,
  parameter logic [71:0] INV_2SIGMA0_SQ = 72'h269F_1783_0777_8415_D2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_done,
  input  logic [71:0]        r_l,
  input  logic [71:0]        r_r,
  input  logic [71:0]        sqr2_isigma,
  input  logic [62:0]        ccs_63,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         z0_l,
  input  logic [4:0]         z0_r,
  input  logic               b_l,
  input  logic               b_r,
  output logic               MUL_data_valid_l,
  output logic               MUL_data_valid_r,
  output logic [80:0]        MUL_data_in_a_l,
  output logic [80:0]        MUL_data_in_a_r,
  output logic [80:0]        MUL_data_in_b_l,
  output logic [80:0]        MUL_data_in_b_r,
  input  logic [80:0]        MUL_data_out_l,
  input  logic [80:0]        MUL_data_out_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [80:0]        x_l,
  output logic [80:0]        x_r,
  output logic signed [5:0]  z_l,
  output logic signed [5:0]  z_r,
  output logic [62:0]        ccs_out,
  output logic [1:0]         x_neg,
  output logic               err
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MUL_LATENCY > 0) ? MUL_LATENCY - 1 : 0);

  typedef enum logic [2:0] {IDLE, SQ, SQ_W, SC, SC_W, SUB, OUT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              params_loaded;
  logic              load_prm, accept, cap_d2, cap_t1, ld_x, mul_vld;

  logic [71:0]       r_l_q, r_r_q, sqr_q;
  logic [62:0]       ccs_q;

  logic signed [5:0]  z_l_nx, z_r_nx;
  logic signed [79:0] diff_l, diff_r;
  logic [78:0]        d_l_p0, d_r_p0;
  logic [8:0]         zsq_l_p0, zsq_r_p0;
  logic [80:0]        d2_l_p1, d2_r_p1;
  logic [80:0]        t1_l_p2, t1_r_p2;
  logic [80:0]        t2_l, t2_r;

  // Distance |v| of a signed Q8.72 value, at most 19 in magnitude.
  function automatic logic [78:0] abs_dist(input logic signed [79:0] v);
    return 79'(v[79] ? -v : v);
  endfunction

  // Difference clamped at zero: x is an unsigned argument for BerExp.
  function automatic logic [80:0] sat_sub(input logic [80:0] a, input logic [80:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  assign load_prm  = pre_done && (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && params_loaded;
  assign out_valid = (state_q == OUT);
  assign MUL_data_valid_l = mul_vld;
  assign MUL_data_valid_r = mul_vld;

  assign z_l_nx = b_l ? ($signed({1'b0, z0_l}) + 6'sd1) : -$signed({1'b0, z0_l});
  assign z_r_nx = b_r ? ($signed({1'b0, z0_r}) + 6'sd1) : -$signed({1'b0, z0_r});
  assign diff_l = $signed({{2{z_l_nx[5]}}, z_l_nx, 72'b0}) - $signed({8'b0, r_l_q});
  assign diff_r = $signed({{2{z_r_nx[5]}}, z_r_nx, 72'b0}) - $signed({8'b0, r_r_q});
  assign t2_l   = {72'b0, zsq_l_p0} * {9'b0, INV_2SIGMA0_SQ};
  assign t2_r   = {72'b0, zsq_r_p0} * {9'b0, INV_2SIGMA0_SQ};

  // Control state: FSM, latency counter, parameter flag and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      params_loaded <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_prm) params_loaded <= 1'b1;
      if (pre_done && (state_q != IDLE)) err <= 1'b1;
    end
  end

  // Next state, multiplier drive and capture strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cap_d2  = 1'b0;
    cap_t1  = 1'b0;
    ld_x    = 1'b0;
    mul_vld = 1'b0;
    MUL_data_in_a_l = '0;
    MUL_data_in_b_l = '0;
    MUL_data_in_a_r = '0;
    MUL_data_in_b_r = '0;
    case (state_q)
      IDLE: begin
        if (in_valid && params_loaded) begin
          accept  = 1'b1;
          state_d = SQ;
        end
      end
      SQ, SQ_W: begin
        MUL_data_in_a_l = {2'b0, d_l_p0};
        MUL_data_in_b_l = {2'b0, d_l_p0};
        MUL_data_in_a_r = {2'b0, d_r_p0};
        MUL_data_in_b_r = {2'b0, d_r_p0};
        mul_vld = (state_q == SQ);
        if ((MUL_LATENCY == 0) || ((state_q == SQ_W) && (cnt_q == CNT_LAST))) begin
          cap_d2  = 1'b1;
          state_d = SC;
        end else if (state_q == SQ) begin
          cnt_d   = '0;
          state_d = SQ_W;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SC, SC_W: begin
        MUL_data_in_a_l = d2_l_p1;
        MUL_data_in_b_l = {9'b0, sqr_q};
        MUL_data_in_a_r = d2_r_p1;
        MUL_data_in_b_r = {9'b0, sqr_q};
        mul_vld = (state_q == SC);
        if ((MUL_LATENCY == 0) || ((state_q == SC_W) && (cnt_q == CNT_LAST))) begin
          cap_t1  = 1'b1;
          state_d = SUB;
        end else if (state_q == SC) begin
          cnt_d   = '0;
          state_d = SC_W;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB: begin
        ld_x    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: parameters, accept stage (p0), square (p1), scaled (p2).
  always_ff @(posedge clk) begin
    if (load_prm) begin
      r_l_q <= r_l;
      r_r_q <= r_r;
      sqr_q <= sqr2_isigma;
      ccs_q <= ccs_63;
    end
    if (accept) begin
      d_l_p0   <= abs_dist(diff_l);
      d_r_p0   <= abs_dist(diff_r);
      zsq_l_p0 <= {4'b0, z0_l} * {4'b0, z0_l};
      zsq_r_p0 <= {4'b0, z0_r} * {4'b0, z0_r};
    end
    if (cap_d2) begin
      d2_l_p1 <= MUL_data_out_l;
      d2_r_p1 <= MUL_data_out_r;
    end
    if (cap_t1) begin
      t1_l_p2 <= MUL_data_out_l;
      t1_r_p2 <= MUL_data_out_r;
    end
  end

  // Result registers presented to BerExp; held while waiting in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_l     <= '0;
      z_r     <= '0;
      x_l     <= '0;
      x_r     <= '0;
      x_neg   <= '0;
      ccs_out <= '0;
    end else begin
      if (accept) begin
        z_l <= z_l_nx;
        z_r <= z_r_nx;
      end
      if (ld_x) begin
        x_l     <= sat_sub(t1_l_p2, t2_l);
        x_r     <= sat_sub(t1_r_p2, t2_r);
        x_neg   <= {(t1_r_p2 < t2_r), (t1_l_p2 < t2_l)};
        ccs_out <= ccs_q;
      end
    end
  end

endmodule

// File: tb/tb_samp_rej_prep.sv
// Directed testbench for samp_rej_prep with an ideal zero-latency multiplier.
module tb_samp_rej_prep;

  localparam logic [71:0] HALF = 72'd1 << 71;
  localparam logic [71:0] INV  = 72'd1 << 69;
  localparam logic [62:0] CCS1 = 63'h1234_5678_9ABC_DEF0;
  localparam logic [62:0] CCS2 = 63'h0FED_CBA9_8765_4321;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre_done = 1'b0;
  logic [71:0] r_l = '0, r_r = '0, sqr2_isigma = '0;
  logic [62:0] ccs_63 = '0;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] z0_l = '0, z0_r = '0;
  logic b_l = 1'b0, b_r = 1'b0;
  logic MUL_data_valid_l, MUL_data_valid_r;
  logic [80:0] MUL_data_in_a_l, MUL_data_in_a_r, MUL_data_in_b_l, MUL_data_in_b_r;
  logic [80:0] MUL_data_out_l, MUL_data_out_r;
  logic out_valid, out_ready = 1'b1;
  logic [80:0] x_l, x_r;
  logic signed [5:0] z_l, z_r;
  logic [62:0] ccs_out;
  logic [1:0] x_neg;
  logic err;

  int n_tests = 0;
  int n_fail = 0;
  int lat;
  logic sq_vld;
  logic [80:0] sq_a_l, sc_a_l, sc_b_l;

  always #5 clk = ~clk;

  // Ideal multiplier: (a*b)>>72 truncated to 81 bits, same cycle.
  assign MUL_data_out_l = 81'(({81'b0, MUL_data_in_a_l} * {81'b0, MUL_data_in_b_l}) >> 72);
  assign MUL_data_out_r = 81'(({81'b0, MUL_data_in_a_r} * {81'b0, MUL_data_in_b_r}) >> 72);

  samp_rej_prep #(.MUL_LATENCY(0), .INV_2SIGMA0_SQ(INV)) dut (
    .clk(clk), .rst_n(rst_n), .pre_done(pre_done), .r_l(r_l), .r_r(r_r),
    .sqr2_isigma(sqr2_isigma), .ccs_63(ccs_63), .in_valid(in_valid), .in_ready(in_ready),
    .z0_l(z0_l), .z0_r(z0_r), .b_l(b_l), .b_r(b_r),
    .MUL_data_valid_l(MUL_data_valid_l), .MUL_data_valid_r(MUL_data_valid_r),
    .MUL_data_in_a_l(MUL_data_in_a_l), .MUL_data_in_a_r(MUL_data_in_a_r),
    .MUL_data_in_b_l(MUL_data_in_b_l), .MUL_data_in_b_r(MUL_data_in_b_r),
    .MUL_data_out_l(MUL_data_out_l), .MUL_data_out_r(MUL_data_out_r),
    .out_valid(out_valid), .out_ready(out_ready), .x_l(x_l), .x_r(x_r),
    .z_l(z_l), .z_r(z_r), .ccs_out(ccs_out), .x_neg(x_neg), .err(err)
  );

  task automatic load_params(input logic [71:0] rl, input logic [71:0] rr,
                             input logic [71:0] sq, input logic [62:0] cc);
    @(posedge clk); #1;
    r_l = rl; r_r = rr; sqr2_isigma = sq; ccs_63 = cc; pre_done = 1'b1;
    @(posedge clk); #1;
    pre_done = 1'b0;
  endtask

  // Accept one job and wait (bounded) for out_valid; lat counts the accept edge as 1.
  task automatic run_job(input logic [4:0] zl, input logic bl_i, input logic [4:0] zr, input logic br_i);
    z0_l = zl; b_l = bl_i; z0_r = zr; b_r = br_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    sq_vld = MUL_data_valid_l & MUL_data_valid_r;
    sq_a_l = MUL_data_in_a_l;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin sc_a_l = MUL_data_in_a_l; sc_b_l = MUL_data_in_b_l; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({out_valid, in_ready, err, x_neg} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 00000", {out_valid, in_ready, err, x_neg}); end
    n_tests++; if ({x_l, x_r, z_l, z_r, ccs_out} !== '0) begin n_fail++; $display("FAIL reset_data got nonzero x_l=%h z_l=%h ccs_out=%h", x_l, z_l, ccs_out); end
    n_tests++; if ({MUL_data_valid_l, MUL_data_valid_r} !== 2'b00) begin n_fail++; $display("FAIL reset_mul_vld got %b want 00", {MUL_data_valid_l, MUL_data_valid_r}); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_params;
    z0_l = 5'd3; z0_r = 5'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++; if ({in_ready, MUL_data_valid_l, MUL_data_valid_r, out_valid} !== 4'b0) begin n_fail++; $display("FAIL no_params cyc%0d got %b want 0000", i, {in_ready, MUL_data_valid_l, MUL_data_valid_r, out_valid}); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_case_a;
    load_params(72'd0, 72'd0, HALF, CCS1);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL a_in_ready got %b want 1", in_ready); end
    run_job(5'd0, 1'b0, 5'd1, 1'b1);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL a_latency got %0d want 4", lat); end
    n_tests++; if (z_l !== 6'sd0 || x_l !== 81'd0 || x_neg !== 2'b00) begin n_fail++; $display("FAIL a_left got z=%h x=%h neg=%b want 0 0 00", z_l, x_l, x_neg); end
    n_tests++; if (z_r !== 6'sd2 || x_r !== (81'd15 << 69)) begin n_fail++; $display("FAIL a_right got z=%h x=%h want 02 %h", z_r, x_r, 81'd15 << 69); end
    n_tests++; if (ccs_out !== CCS1) begin n_fail++; $display("FAIL a_ccs got %h want %h", ccs_out, CCS1); end
  endtask

  task automatic test_case_b;
    load_params(HALF, 72'd0, HALF, CCS2);
    run_job(5'd2, 1'b1, 5'd3, 1'b0);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL b_latency got %0d want 4", lat); end
    n_tests++; if (sq_vld !== 1'b1 || sq_a_l !== (81'd5 << 71)) begin n_fail++; $display("FAIL b_sq_issue got vld=%b a=%h want 1 %h", sq_vld, sq_a_l, 81'd5 << 71); end
    n_tests++; if (sc_a_l !== (81'd25 << 70) || sc_b_l !== (81'd1 << 71)) begin n_fail++; $display("FAIL b_sc_issue got a=%h b=%h", sc_a_l, sc_b_l); end
    n_tests++; if (z_l !== 6'sd3 || x_l !== (81'd21 << 69)) begin n_fail++; $display("FAIL b_left got z=%h x=%h want 03 %h", z_l, x_l, 81'd21 << 69); end
    n_tests++; if (z_r !== 6'h3D || x_r !== (81'd27 << 69) || x_neg !== 2'b00) begin n_fail++; $display("FAIL b_right got z=%h x=%h neg=%b", z_r, x_r, x_neg); end
    n_tests++; if (ccs_out !== CCS2) begin n_fail++; $display("FAIL b_ccs got %h want %h", ccs_out, CCS2); end
    @(posedge clk); #1;
    n_tests++; if ({MUL_data_valid_l, MUL_data_in_a_l, MUL_data_in_b_r} !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b_idle_mul got vld=%b a=%h rdy=%b", MUL_data_valid_l, MUL_data_in_a_l, in_ready); end
  endtask

  task automatic test_case_c;
    load_params(72'd0, 72'd0, 72'd0, CCS1);
    run_job(5'd18, 1'b1, 5'd4, 1'b0);
    n_tests++; if (z_l !== 6'h13 || x_l !== 81'd0) begin n_fail++; $display("FAIL c_left got z=%h x=%h want 13 0", z_l, x_l); end
    n_tests++; if (z_r !== 6'h3C || x_r !== 81'd0) begin n_fail++; $display("FAIL c_right got z=%h x=%h want 3c 0", z_r, x_r); end
    n_tests++; if (x_neg !== 2'b11) begin n_fail++; $display("FAIL c_x_neg got %b want 11", x_neg); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL c_err got %b want 0", err); end
  endtask

  task automatic test_stall;
    load_params(72'd0, 72'd0, HALF, CCS2);
    out_ready = 1'b0;
    run_job(5'd18, 1'b0, 5'd0, 1'b1);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL d_latency got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z_l !== 6'h2E || x_l !== (81'd243 << 71) ||
          z_r !== 6'sd1 || x_r !== (81'd1 << 71) || x_neg !== 2'b00 || ccs_out !== CCS2) begin
        n_fail++; $display("FAIL d_hold cyc%0d got vld=%b rdy=%b z_l=%h x_l=%h z_r=%h x_r=%h", i, out_valid, in_ready, z_l, x_l, z_r, x_r);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL d_release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_err;
    load_params(72'd0, 72'd0, HALF, CCS1);
    z0_l = 5'd1; b_l = 1'b1; z0_r = 5'd0; b_r = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    r_l = HALF; sqr2_isigma = 72'd0; ccs_63 = CCS2; pre_done = 1'b1;
    @(posedge clk); #1;
    pre_done = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL e_err_set got %b want 1", err); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL e_out_wait got %0d want 1", lat); end
    n_tests++; if (x_l !== (81'd15 << 69) || z_r !== 6'sd0 || x_r !== 81'd0 || ccs_out !== CCS1) begin n_fail++; $display("FAIL e_params_kept got x_l=%h x_r=%h ccs=%h", x_l, x_r, ccs_out); end
    @(posedge clk); #1;
    run_job(5'd1, 1'b1, 5'd0, 1'b0);
    n_tests++; if (x_l !== (81'd15 << 69) || ccs_out !== CCS1 || err !== 1'b1) begin n_fail++; $display("FAIL e_rerun got x_l=%h ccs=%h err=%b", x_l, ccs_out, err); end
  endtask

  task automatic test_reset_mid_job;
    load_params(72'd0, 72'd0, HALF, CCS1);
    z0_l = 5'd2; b_l = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({out_valid, in_ready, err, MUL_data_valid_l} !== 4'b0) begin n_fail++; $display("FAIL rst_sc got vld=%b rdy=%b err=%b mul=%b want 0000", out_valid, in_ready, err, MUL_data_valid_l); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sc_after got vld=%b rdy=%b want 0 0", out_valid, in_ready); end
    load_params(72'd0, 72'd0, HALF, CCS1);
    out_ready = 1'b0;
    run_job(5'd1, 1'b1, 5'd1, 1'b1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_out_setup got vld=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || x_l !== 81'd0) begin n_fail++; $display("FAIL rst_out got vld=%b x_l=%h want 0 0", out_valid, x_l); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_no_params();
    test_case_a();
    test_case_b();
    test_case_c();
    test_stall();
    test_err();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
